// File: rtl/pipe_instr_ctrl.sv
// rtl/pipe_instr_ctrl.sv - five-stage instruction pipeline register control with load-use stall and branch flush
module pipe_instr_ctrl #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] InstrF,
    input  logic        RegWriteD,
    input  logic        PCSrcE,
    input  logic        MemBusy,
    output logic [31:0] InstrD,
    output logic [31:0] InstrE,
    output logic [31:0] InstrM,
    output logic [31:0] InstrW,
    output logic        RegWriteE,
    output logic        RegWriteM,
    output logic        RegWriteW,
    output logic        ValidE,
    output logic        ValidM,
    output logic        ValidW,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushD,
    output logic        FlushE,
    output logic [15:0] StallCount
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [6:0] opcode_d;
    logic [4:0] rs1_d;
    logic [4:0] rs2_d;
    logic [4:0] rd_e;
    logic       uses_rs2_d;
    logic       load_e;
    logic       hazard;

    assign opcode_d = InstrD[6:0];
    assign rs1_d    = InstrD[19:15];
    assign rs2_d    = InstrD[24:20];
    assign rd_e     = InstrE[11:7];

    always_comb begin
        uses_rs2_d = 1'b0;
        case (opcode_d)
            OP_RTYPE, OP_STORE, OP_BRANCH: uses_rs2_d = 1'b1;
            default:                       uses_rs2_d = 1'b0;
        endcase
    end

    assign load_e = (InstrE[6:0] == OP_LOAD) && ValidE;
    assign hazard = load_e && (rd_e != 5'd0) &&
                    ((rs1_d == rd_e) || (uses_rs2_d && (rs2_d == rd_e)));

    // A taken branch discards the dependent instruction, so it suppresses the stall.
    assign StallF = hazard & ~PCSrcE;
    assign StallD = hazard & ~PCSrcE;
    assign FlushD = PCSrcE;
    assign FlushE = PCSrcE | hazard;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            InstrD <= NOP_INSTR;
        end else if (!MemBusy) begin
            if (FlushD) begin
                InstrD <= NOP_INSTR;
            end else if (!StallD) begin
                InstrD <= InstrF;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            InstrE    <= NOP_INSTR;
            RegWriteE <= 1'b0;
            ValidE    <= 1'b0;
        end else if (!MemBusy) begin
            if (FlushE) begin
                InstrE    <= NOP_INSTR;
                RegWriteE <= 1'b0;
                ValidE    <= 1'b0;
            end else begin
                InstrE    <= InstrD;
                RegWriteE <= RegWriteD;
                ValidE    <= (InstrD != NOP_INSTR);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            InstrM    <= NOP_INSTR;
            RegWriteM <= 1'b0;
            ValidM    <= 1'b0;
            InstrW    <= NOP_INSTR;
            RegWriteW <= 1'b0;
            ValidW    <= 1'b0;
        end else if (!MemBusy) begin
            InstrM    <= InstrE;
            RegWriteM <= RegWriteE;
            ValidM    <= ValidE;
            InstrW    <= InstrM;
            RegWriteW <= RegWriteM;
            ValidW    <= ValidM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            StallCount <= 16'd0;
        end else if (!MemBusy && StallD && (StallCount != 16'hFFFF)) begin
            StallCount <= StallCount + 16'd1;
        end
    end

endmodule

// File: tb/tb_pipe_instr_ctrl.sv
// tb/tb_pipe_instr_ctrl.sv - directed and randomized model-based bench for pipe_instr_ctrl
module tb_pipe_instr_ctrl;

    localparam logic [31:0] NOP     = 32'h00000013;
    localparam logic [31:0] ADDI    = 32'h00500093;
    localparam logic [31:0] LW_X5   = 32'h0000A283;
    localparam logic [31:0] ADD_X5  = 32'h00228333;
    localparam logic [31:0] LW_X0   = 32'h0000A003;
    localparam logic [31:0] ADD_X0  = 32'h00000333;
    localparam logic [31:0] BEQ     = 32'h00208463;
    localparam logic [31:0] ADDI_X2 = 32'h00100113;
    localparam logic [31:0] ADDI_X3 = 32'h00200193;
    localparam logic [31:0] ADDI_X4 = 32'h00300213;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] InstrF;
    logic        RegWriteD, PCSrcE, MemBusy;
    logic [31:0] InstrD, InstrE, InstrM, InstrW;
    logic        RegWriteE, RegWriteM, RegWriteW;
    logic        ValidE, ValidM, ValidW;
    logic        StallF, StallD, FlushD, FlushE;
    logic [15:0] StallCount;

    int checks = 0;
    int errors = 0;

    // Reference pipeline: index 0=D, 1=E, 2=M, 3=W
    logic [31:0] ref_instr [4];
    logic        ref_rw    [4];
    logic        ref_v     [4];
    int          ref_cnt;

    pipe_instr_ctrl #(.NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .InstrF(InstrF), .RegWriteD(RegWriteD),
        .PCSrcE(PCSrcE), .MemBusy(MemBusy),
        .InstrD(InstrD), .InstrE(InstrE), .InstrM(InstrM), .InstrW(InstrW),
        .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ValidE(ValidE), .ValidM(ValidM), .ValidW(ValidW),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .StallCount(StallCount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; InstrF = NOP; RegWriteD = 1'b0; PCSrcE = 1'b0; MemBusy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    function automatic logic ref_hazard(input logic [31:0] d, input logic [31:0] e, input logic ve);
        logic uses2;
        uses2 = (d[6:0] == 7'b0110011) || (d[6:0] == 7'b0100011) || (d[6:0] == 7'b1100011);
        return (e[6:0] == 7'b0000011) && ve && (e[11:7] != 5'd0) &&
               ((d[19:15] == e[11:7]) || (uses2 && (d[24:20] == e[11:7])));
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  ops [5];
        ops = '{7'b0000011, 7'b0110011, 7'b0100011, 7'b1100011, 7'b0010011};
        if ($urandom_range(0, 7) == 0) return NOP;
        r = $urandom;
        r[6:0]   = ops[$urandom_range(0, 4)];
        r[11:7]  = 5'($urandom_range(0, 3));
        r[19:15] = 5'($urandom_range(0, 3));
        r[24:20] = 5'($urandom_range(0, 3));
        return r;
    endfunction

    task automatic test_reset();
        rst = 1'b1; InstrF = ADDI; RegWriteD = 1'b1; PCSrcE = 1'b0; MemBusy = 1'b1;
        tick();
        checks++;
        if ({InstrD, InstrE, InstrM, InstrW} !== {4{NOP}}) begin
            errors++; $display("FAIL reset_instr: got %h %h %h %h want all %h", InstrD, InstrE, InstrM, InstrW, NOP);
        end
        checks++;
        if ({RegWriteE, RegWriteM, RegWriteW, ValidE, ValidM, ValidW, StallCount} !== 22'd0) begin
            errors++; $display("FAIL reset_flags: got rw=%b%b%b v=%b%b%b cnt=%0d want zeros",
                               RegWriteE, RegWriteM, RegWriteW, ValidE, ValidM, ValidW, StallCount);
        end
        rst = 1'b0; MemBusy = 1'b0; PCSrcE = 1'b1;
        #1;
        checks++;
        if ({StallF, StallD, FlushD, FlushE} !== 4'b0011) begin
            errors++; $display("FAIL reset_comb_pc1: got sf=%b sd=%b fd=%b fe=%b want 0011", StallF, StallD, FlushD, FlushE);
        end
        PCSrcE = 1'b0;
        #1;
        checks++;
        if ({StallF, StallD, FlushD, FlushE} !== 4'b0000) begin
            errors++; $display("FAIL reset_comb_pc0: got sf=%b sd=%b fd=%b fe=%b want 0000", StallF, StallD, FlushD, FlushE);
        end
    endtask

    task automatic test_straight_line();
        int bad = 0;
        do_reset();
        InstrF = ADDI;
        for (int e = 1; e <= 4; e++) begin
            if ({StallF, StallD, FlushD, FlushE} !== 4'b0000) bad++;
            tick();
            InstrF = NOP;
            RegWriteD = (e == 1);
        end
        checks++;
        if (InstrW !== ADDI || RegWriteW !== 1'b1 || ValidW !== 1'b1) begin
            errors++; $display("FAIL straight_w: got InstrW=%h rw=%b v=%b want %h 1 1", InstrW, RegWriteW, ValidW, ADDI);
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL straight_noctl: got %0d cycles with stall/flush want 0", bad);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        InstrF = LW_X5; tick();
        InstrF = ADD_X5; tick();
        InstrF = NOP;
        checks++;
        if ({StallF, StallD, FlushD, FlushE} !== 4'b1101) begin
            errors++; $display("FAIL loaduse_comb: got sf=%b sd=%b fd=%b fe=%b want 1101", StallF, StallD, FlushD, FlushE);
        end
        tick();
        checks++;
        if (InstrE !== NOP || ValidE !== 1'b0 || InstrM !== LW_X5 || InstrD !== ADD_X5 || StallCount !== 16'd1) begin
            errors++; $display("FAIL loaduse_regs: got E=%h vE=%b M=%h D=%h cnt=%0d want %h 0 %h %h 1",
                               InstrE, ValidE, InstrM, InstrD, StallCount, NOP, LW_X5, ADD_X5);
        end
        checks++;
        if ({StallF, StallD, FlushE} !== 3'b000) begin
            errors++; $display("FAIL loaduse_oneshot: got sf=%b sd=%b fe=%b want 000", StallF, StallD, FlushE);
        end
    endtask

    task automatic test_rd_x0();
        do_reset();
        InstrF = LW_X0; tick();
        InstrF = ADD_X0; tick();
        checks++;
        if ({StallF, StallD, FlushE} !== 3'b000) begin
            errors++; $display("FAIL rdx0_nostall: got sf=%b sd=%b fe=%b want 000", StallF, StallD, FlushE);
        end
    endtask

    task automatic test_branch_flush();
        do_reset();
        InstrF = BEQ; tick();
        InstrF = ADDI; tick();
        PCSrcE = 1'b1; InstrF = ADDI_X2;
        #1;
        checks++;
        if ({StallD, FlushD, FlushE} !== 3'b011) begin
            errors++; $display("FAIL branch_comb: got sd=%b fd=%b fe=%b want 011", StallD, FlushD, FlushE);
        end
        tick();
        PCSrcE = 1'b0;
        checks++;
        if (InstrD !== NOP || InstrE !== NOP || ValidE !== 1'b0 || InstrM !== BEQ || ValidM !== 1'b1) begin
            errors++; $display("FAIL branch_regs: got D=%h E=%h vE=%b M=%h vM=%b want %h %h 0 %h 1",
                               InstrD, InstrE, ValidE, InstrM, ValidM, NOP, NOP, BEQ);
        end
    endtask

    task automatic test_branch_over_hazard();
        do_reset();
        InstrF = LW_X5; tick();
        InstrF = ADD_X5; tick();
        PCSrcE = 1'b1;
        #1;
        checks++;
        if ({StallF, StallD, FlushD, FlushE} !== 4'b0011) begin
            errors++; $display("FAIL brhaz_comb: got sf=%b sd=%b fd=%b fe=%b want 0011", StallF, StallD, FlushD, FlushE);
        end
        tick();
        PCSrcE = 1'b0;
        checks++;
        if (InstrD !== NOP || InstrE !== NOP || StallCount !== 16'd0) begin
            errors++; $display("FAIL brhaz_regs: got D=%h E=%h cnt=%0d want %h %h 0", InstrD, InstrE, StallCount, NOP, NOP);
        end
    endtask

    task automatic test_freeze_reset();
        int bad = 0;
        do_reset();
        RegWriteD = 1'b1;
        InstrF = ADDI_X2; tick();
        InstrF = ADDI_X3; tick();
        InstrF = BEQ;     tick();
        InstrF = ADDI_X4; tick();
        MemBusy = 1'b1; PCSrcE = 1'b1; InstrF = ADDI;
        for (int i = 0; i < 3; i++) begin
            tick();
            if ({InstrD, InstrE, InstrM, InstrW} !== {ADDI_X4, BEQ, ADDI_X3, ADDI_X2} ||
                {RegWriteE, RegWriteM, RegWriteW, ValidE, ValidM, ValidW} !== 6'b111111 ||
                FlushD !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL freeze_hold: got %0d changed cycles D=%h E=%h M=%h W=%h want 0", bad, InstrD, InstrE, InstrM, InstrW);
        end
        MemBusy = 1'b0;
        tick();
        PCSrcE = 1'b0;
        checks++;
        if (InstrD !== NOP || InstrE !== NOP || InstrM !== BEQ || InstrW !== ADDI_X3) begin
            errors++; $display("FAIL freeze_release: got D=%h E=%h M=%h W=%h want %h %h %h %h",
                               InstrD, InstrE, InstrM, InstrW, NOP, NOP, BEQ, ADDI_X3);
        end
        // accumulate one stall, then freeze on a second hazard and reset mid-cycle
        InstrF = LW_X5; tick();
        InstrF = ADD_X5; tick();
        tick();
        InstrF = LW_X5; tick();
        InstrF = ADD_X5; tick();
        MemBusy = 1'b1; PCSrcE = 1'b1;
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({InstrD, InstrE, InstrM, InstrW} !== {4{NOP}} || StallCount !== 16'd0 ||
            {RegWriteE, RegWriteM, RegWriteW, ValidE, ValidM, ValidW} !== 6'd0) begin
            errors++; $display("FAIL freeze_rst_regs: got D=%h E=%h M=%h W=%h cnt=%0d want NOPs cnt 0",
                               InstrD, InstrE, InstrM, InstrW, StallCount);
        end
        checks++;
        if ({StallF, StallD, FlushD, FlushE} !== 4'b0011) begin
            errors++; $display("FAIL freeze_rst_comb: got sf=%b sd=%b fd=%b fe=%b want 0011", StallF, StallD, FlushD, FlushE);
        end
        tick();
        rst = 1'b0; MemBusy = 1'b0; PCSrcE = 1'b0;
    endtask

    task automatic test_random();
        logic hz, stall, flush_e;
        logic [31:0] nxt_d;
        do_reset();
        for (int s = 0; s < 4; s++) begin
            ref_instr[s] = NOP; ref_rw[s] = 1'b0; ref_v[s] = 1'b0;
        end
        ref_cnt = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            InstrF    = rand_instr();
            RegWriteD = 1'($urandom_range(0, 1));
            PCSrcE    = ($urandom_range(0, 7) == 0);
            MemBusy   = ($urandom_range(0, 5) == 0);
            #1;
            hz      = ref_hazard(ref_instr[0], ref_instr[1], ref_v[1]);
            stall   = hz && !PCSrcE;
            flush_e = PCSrcE || hz;
            checks++;
            if ({StallF, StallD, FlushD, FlushE} !== {stall, stall, PCSrcE, flush_e}) begin
                errors++; $display("FAIL rand_comb cyc %0d: got %b%b%b%b want %b%b%b%b", cyc,
                                   StallF, StallD, FlushD, FlushE, stall, stall, PCSrcE, flush_e);
            end
            if (!MemBusy) begin
                for (int s = 3; s >= 2; s--) begin
                    ref_instr[s] = ref_instr[s-1]; ref_rw[s] = ref_rw[s-1]; ref_v[s] = ref_v[s-1];
                end
                if (flush_e) begin
                    ref_instr[1] = NOP; ref_rw[1] = 1'b0; ref_v[1] = 1'b0;
                end else begin
                    ref_v[1] = (ref_instr[0] != NOP); ref_rw[1] = RegWriteD; ref_instr[1] = ref_instr[0];
                end
                nxt_d = PCSrcE ? NOP : (stall ? ref_instr[0] : InstrF);
                ref_instr[0] = nxt_d;
                if (stall && ref_cnt < 65535) ref_cnt++;
            end
            tick();
            checks++;
            if ({InstrD, InstrE, InstrM, InstrW} !== {ref_instr[0], ref_instr[1], ref_instr[2], ref_instr[3]} ||
                {RegWriteE, RegWriteM, RegWriteW} !== {ref_rw[1], ref_rw[2], ref_rw[3]} ||
                {ValidE, ValidM, ValidW} !== {ref_v[1], ref_v[2], ref_v[3]} ||
                StallCount !== 16'(ref_cnt)) begin
                errors++; $display("FAIL rand_regs cyc %0d: got D=%h E=%h M=%h W=%h rw=%b%b%b v=%b%b%b cnt=%0d want D=%h E=%h M=%h W=%h rw=%b%b%b v=%b%b%b cnt=%0d",
                                   cyc, InstrD, InstrE, InstrM, InstrW, RegWriteE, RegWriteM, RegWriteW,
                                   ValidE, ValidM, ValidW, StallCount,
                                   ref_instr[0], ref_instr[1], ref_instr[2], ref_instr[3],
                                   ref_rw[1], ref_rw[2], ref_rw[3], ref_v[1], ref_v[2], ref_v[3], ref_cnt);
            end
        end
    endtask

    initial begin
        rst = 1'b1; InstrF = NOP; RegWriteD = 1'b0; PCSrcE = 1'b0; MemBusy = 1'b0;
        test_reset();
        test_straight_line();
        test_load_use();
        test_rd_x0();
        test_branch_flush();
        test_branch_over_hazard();
        test_freeze_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
